// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - MIPS IF stage: PC, IM fetch and DEPTH-entry instruction FIFO with branch delay slot.
// Optional define IFQ_BYPASS_EN: a fetch into an empty queue is presented on out_* in the same cycle.
module instruction_fetch_queue #(
   parameter int unsigned  DEPTH      = 4,
   parameter logic [31:0]  RESET_PC   = 32'h0000_3000,
   parameter logic [31:0]  EXC_VECTOR = 32'h0000_4180
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [31:0]              im_addr,
   input  logic [31:0]              im_inst,
   input  logic                     im_accepted,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_pc4,
   output logic [31:0]              out_inst,
   output logic                     out_exception,
   output logic [4:0]               out_exccode,
   input  logic                     redirect,
   input  logic [31:0]              redirect_target,
   input  logic                     handle_exception,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   typedef enum logic [1:0] {ST_RUN, ST_DS_WAIT, ST_HALT} state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [31:0]     r_pc;
   logic [31:0]     w_next_pc;
   logic [31:0]     r_target;
   logic            w_latch_target;

   logic [31:0]     r_mem_pc   [DEPTH];
   logic [31:0]     r_mem_inst [DEPTH];
   logic            r_mem_exc  [DEPTH];
   logic [AW-1:0]   r_rd_ptr;
   logic [AW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;

   logic            w_fault;
   logic            w_stored;
   logic            w_full;
   logic            w_fetch_base;
   logic            w_bypass;
   logic            w_deq;
   logic            w_deq_store;
   logic            w_redir;
   logic            w_kill;
   logic            w_fetch;
   logic            w_enq;
   logic [31:0]     w_fetch_inst;

   assign im_addr      = r_pc;
   assign count        = r_count;
   assign w_fault      = ~im_accepted | (r_pc[1:0] != 2'b00);
   assign w_fetch_inst = w_fault ? 32'h0 : im_inst;
   assign w_stored     = (r_count != '0);
   assign w_full       = (r_count == CW'(DEPTH));

   // A full queue only makes room when its head leaves, so out_ready stands in for the dequeue here.
   assign w_fetch_base = (r_state != ST_HALT) & ~handle_exception & (~w_full | out_ready);

`ifdef IFQ_BYPASS_EN
   assign w_bypass = ~w_stored & w_fetch_base;
`else
   assign w_bypass = 1'b0;
`endif

   assign out_valid   = w_stored | w_bypass;
   assign w_deq       = out_valid & out_ready;
   assign w_deq_store = w_stored & out_ready;
   assign w_redir     = redirect & w_deq & ~handle_exception;

   // Delay slot already queued behind the branch: drop everything younger and skip this fetch.
   assign w_kill  = w_redir & (r_count >= CW'(2));
   assign w_fetch = w_fetch_base & ~w_kill;
   assign w_enq   = w_fetch & ~(w_bypass & out_ready);

   always_comb begin
      out_pc        = 32'h0;
      out_inst      = 32'h0;
      out_exception = 1'b0;
      if (w_stored) begin
         out_pc        = r_mem_pc[r_rd_ptr];
         out_inst      = r_mem_inst[r_rd_ptr];
         out_exception = r_mem_exc[r_rd_ptr];
      end else if (w_bypass) begin
         out_pc        = r_pc;
         out_inst      = w_fetch_inst;
         out_exception = w_fault;
      end
      out_pc4     = out_pc + 32'd4;
      out_exccode = out_exception ? EXC_ADEL : 5'd0;
   end

   always_comb begin
      w_next_state   = r_state;
      w_next_pc      = r_pc;
      w_latch_target = 1'b0;
      if (handle_exception) begin
         w_next_state = ST_RUN;
         w_next_pc    = EXC_VECTOR;
      end else begin
         if (w_fetch) begin
            if (r_state == ST_DS_WAIT) begin
               w_next_pc    = r_target;
               w_next_state = ST_RUN;
            end else begin
               w_next_pc = r_pc + 32'd4;
            end
         end
         if (w_kill) begin
            w_next_pc    = redirect_target;
            w_next_state = ST_RUN;
         end else if (w_redir && w_enq) begin
            w_next_pc    = redirect_target;
            w_next_state = ST_RUN;
         end else if (w_redir) begin
            w_latch_target = 1'b1;
            w_next_state   = ST_DS_WAIT;
         end
         if (w_fetch && w_fault) begin
            w_next_state = ST_HALT;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc     <= RESET_PC;
         r_target <= 32'h0;
      end else begin
         r_pc <= w_next_pc;
         if (w_latch_target) begin
            r_target <= redirect_target;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (handle_exception) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_kill) begin
         r_rd_ptr <= r_rd_ptr + AW'(1);
         r_wr_ptr <= r_rd_ptr + AW'(2);
         r_count  <= CW'(1);
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_deq_store) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_enq) - CW'(w_deq_store);
      end
   end

   // Storage needs no reset: nothing is read unless r_count marks it valid.
   always_ff @(posedge clk) begin
      if (w_enq && !handle_exception) begin
         r_mem_pc[r_wr_ptr]   <= r_pc;
         r_mem_inst[r_wr_ptr] <= w_fetch_inst;
         r_mem_exc[r_wr_ptr]  <= w_fault;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - directed self-checking bench for instruction_fetch_queue (default build, DEPTH=4).
module tb_instruction_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] im_addr;
   logic [31:0] im_inst;
   logic        im_accepted;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;
   logic [31:0] out_inst;
   logic        out_exception;
   logic [4:0]  out_exccode;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        handle_exception;
   logic [2:0]  count;

   logic        rej_en;
   logic [31:0] rej_addr;
   int          n_checks = 0;
   int          n_fail   = 0;

   instruction_fetch_queue #(
      .DEPTH      (4),
      .RESET_PC   (32'h0000_3000),
      .EXC_VECTOR (32'h0000_4180)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .im_addr          (im_addr),
      .im_inst          (im_inst),
      .im_accepted      (im_accepted),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_pc           (out_pc),
      .out_pc4          (out_pc4),
      .out_inst         (out_inst),
      .out_exception    (out_exception),
      .out_exccode      (out_exccode),
      .redirect         (redirect),
      .redirect_target  (redirect_target),
      .handle_exception (handle_exception),
      .count            (count)
   );

   always #5 clk = ~clk;

   assign im_inst     = {im_addr[15:0] ^ 16'hA5A5, im_addr[15:0]};
   assign im_accepted = ~(rej_en && (im_addr == rej_addr));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic rdy, input logic rej, input logic [31:0] raddr);
      reset            = 1'b1;
      redirect         = 1'b0;
      redirect_target  = 32'h0;
      handle_exception = 1'b0;
      out_ready        = rdy;
      rej_en           = rej;
      rej_addr         = raddr;
      @(posedge clk);
      #3;
      reset = 1'b0;
   endtask

   initial begin
      reset            = 1'b1;
      redirect         = 1'b0;
      redirect_target  = 32'h0;
      handle_exception = 1'b0;
      out_ready        = 1'b1;
      rej_en           = 1'b0;
      rej_addr         = 32'h0;
      #2;
      check_eq("rst_count",   32'(count), 32'h0);
      check_eq("rst_valid",   32'(out_valid), 32'h0);
      check_eq("rst_im_addr", im_addr, 32'h3000);
      check_eq("rst_out_pc",  out_pc, 32'h0);
      check_eq("rst_inst",    out_inst, 32'h0);
      check_eq("rst_exc",     32'(out_exception), 32'h0);
      check_eq("rst_exccode", 32'(out_exccode), 32'h0);
      @(posedge clk);
      #3;
      reset = 1'b0;

      // streaming with out_ready held high
      tick(1);
      check_eq("s1_valid", 32'(out_valid), 32'h1);
      check_eq("s1_pc",    out_pc, 32'h3000);
      check_eq("s1_pc4",   out_pc4, 32'h3004);
      check_eq("s1_inst",  out_inst, 32'h95A5_3000);
      check_eq("s1_im",    im_addr, 32'h3004);
      check_eq("s1_count", 32'(count), 32'h1);
      tick(1);
      check_eq("s2_pc",    out_pc, 32'h3004);
      check_eq("s2_im",    im_addr, 32'h3008);
      tick(1);
      check_eq("s3_pc",    out_pc, 32'h3008);

      // fill to DEPTH, then drain at full rate
      do_reset(1'b0, 1'b0, 32'h0);
      tick(10);
      check_eq("full_count", 32'(count), 32'h4);
      check_eq("full_im",    im_addr, 32'h3010);
      check_eq("full_pc",    out_pc, 32'h3000);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("drain_pc", out_pc, 32'h3000 + 32'(4 * i));
         tick(1);
      end
      check_eq("drain_count", 32'(count), 32'h4);
      check_eq("drain_im",    im_addr, 32'h3020);

      // redirect with delay slot already queued (count=3)
      do_reset(1'b0, 1'b0, 32'h0);
      tick(3);
      check_eq("br3_count0", 32'(count), 32'h3);
      out_ready       = 1'b1;
      redirect        = 1'b1;
      redirect_target = 32'h3100;
      tick(1);
      redirect = 1'b0;
      check_eq("br3_ds_pc",  out_pc, 32'h3004);
      check_eq("br3_count",  32'(count), 32'h1);
      check_eq("br3_im",     im_addr, 32'h3100);
      tick(1);
      check_eq("br3_tgt_pc", out_pc, 32'h3100);
      check_eq("br3_im2",    im_addr, 32'h3104);

      // redirect with count=1: delay slot is this cycle's fetch
      do_reset(1'b0, 1'b0, 32'h0);
      tick(1);
      out_ready       = 1'b1;
      redirect        = 1'b1;
      redirect_target = 32'h3100;
      tick(1);
      redirect = 1'b0;
      check_eq("br1_ds_pc",  out_pc, 32'h3004);
      check_eq("br1_im",     im_addr, 32'h3100);
      tick(1);
      check_eq("br1_tgt_pc", out_pc, 32'h3100);
      tick(1);
      check_eq("br1_next",   out_pc, 32'h3104);

      // misaligned redirect target faults and halts fetch
      do_reset(1'b0, 1'b0, 32'h0);
      tick(2);
      out_ready       = 1'b1;
      redirect        = 1'b1;
      redirect_target = 32'h3102;
      tick(1);
      redirect  = 1'b0;
      out_ready = 1'b0;
      check_eq("mis_ds_pc", out_pc, 32'h3004);
      check_eq("mis_im",    im_addr, 32'h3102);
      tick(1);
      check_eq("mis_count", 32'(count), 32'h2);
      tick(1);
      check_eq("halt_count", 32'(count), 32'h2);
      check_eq("halt_im",    im_addr, 32'h3106);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      check_eq("mis_pc",      out_pc, 32'h3102);
      check_eq("mis_exc",     32'(out_exception), 32'h1);
      check_eq("mis_exccode", 32'(out_exccode), 32'h4);
      check_eq("mis_inst",    out_inst, 32'h0);
      tick(2);
      check_eq("halt_im2",    im_addr, 32'h3106);
      check_eq("halt_count2", 32'(count), 32'h1);
      handle_exception = 1'b1;
      tick(1);
      handle_exception = 1'b0;
      check_eq("exc_count", 32'(count), 32'h0);
      check_eq("exc_valid", 32'(out_valid), 32'h0);
      check_eq("exc_im",    im_addr, 32'h4180);
      tick(1);
      check_eq("exc_pc",    out_pc, 32'h4180);
      check_eq("exc_im2",   im_addr, 32'h4184);

      // IM rejects 0x3008; handle_exception beats a simultaneous redirect
      do_reset(1'b0, 1'b1, 32'h3008);
      tick(4);
      check_eq("rej_count", 32'(count), 32'h3);
      out_ready = 1'b1;
      tick(2);
      check_eq("rej_pc",      out_pc, 32'h3008);
      check_eq("rej_exc",     32'(out_exception), 32'h1);
      check_eq("rej_exccode", 32'(out_exccode), 32'h4);
      check_eq("rej_inst",    out_inst, 32'h0);
      handle_exception = 1'b1;
      redirect         = 1'b1;
      redirect_target  = 32'h3100;
      tick(1);
      handle_exception = 1'b0;
      redirect         = 1'b0;
      check_eq("he_count", 32'(count), 32'h0);
      check_eq("he_valid", 32'(out_valid), 32'h0);
      check_eq("he_im",    im_addr, 32'h4180);
      tick(1);
      check_eq("he_pc",    out_pc, 32'h4180);

      // redirect out of HALT with nothing queued goes through DS_WAIT
      do_reset(1'b0, 1'b1, 32'h3004);
      tick(3);
      check_eq("dsw_count0", 32'(count), 32'h2);
      check_eq("dsw_im0",    im_addr, 32'h3008);
      out_ready = 1'b1;
      tick(1);
      check_eq("dsw_head_exc", 32'(out_exception), 32'h1);
      redirect        = 1'b1;
      redirect_target = 32'h3200;
      tick(1);
      redirect  = 1'b0;
      out_ready = 1'b0;
      check_eq("dsw_count1", 32'(count), 32'h0);
      check_eq("dsw_valid",  32'(out_valid), 32'h0);
      check_eq("dsw_im1",    im_addr, 32'h3008);
      tick(1);
      check_eq("dsw_ds_pc",  out_pc, 32'h3008);
      check_eq("dsw_ds_exc", 32'(out_exception), 32'h0);
      check_eq("dsw_im2",    im_addr, 32'h3200);
      tick(2);
      check_eq("dsw_count3", 32'(count), 32'h3);
      check_eq("dsw_im3",    im_addr, 32'h3208);

      // asynchronous reset mid-operation
      #3;
      reset = 1'b1;
      #1;
      check_eq("arst_count", 32'(count), 32'h0);
      check_eq("arst_valid", 32'(out_valid), 32'h0);
      check_eq("arst_im",    im_addr, 32'h3000);
      #2;
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
